// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and its consumers
// (pixel renderer, HDMI transmitter). The consumer supplies the pixel-rate enable.
interface vga_timing_gen_if #(
    parameter int CNT_W   = 12,
    parameter int FRAME_W = 16
);
    logic               pixelEnable;
    logic [CNT_W-1:0]   pixelH;
    logic [CNT_W-1:0]   pixelV;
    logic               hsync;
    logic               vsync;
    logic               dataEnable;
    logic               lineStart;
    logic               frameStart;
    logic [FRAME_W-1:0] frameCount;

    modport master (
        input  pixelEnable,
        output pixelH, pixelV, hsync, vsync, dataEnable,
        output lineStart, frameStart, frameCount
    );

    modport slave (
        output pixelEnable,
        input  pixelH, pixelV, hsync, vsync, dataEnable,
        input  lineStart, frameStart, frameCount
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator on a single clock with a pixel-rate enable.
// Every output is registered and describes the same (pixelH, pixelV) in the same cycle.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CNT_W    = 12,
    parameter int FRAME_W  = 16
) (
    input logic            clock,
    input logic            reset,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int W1      = CNT_W + 1;

    generate
        if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_total_check
            $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
        end
        if (H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1) begin : g_width_check
            $error("vga_timing_gen: active and sync widths must be at least 1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Decode bounds carry one spare bit so an edge equal to 2**CNT_W cannot alias to 0.
    localparam logic [W1-1:0] H_ACT_END  = W1'(H_ACTIVE);
    localparam logic [W1-1:0] V_ACT_END  = W1'(V_ACTIVE);
    localparam logic [W1-1:0] HS_START   = W1'(H_ACTIVE + H_FP);
    localparam logic [W1-1:0] HS_END     = W1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [W1-1:0] VS_START   = W1'(V_ACTIVE + V_FP);
    localparam logic [W1-1:0] VS_END     = W1'(V_ACTIVE + V_FP + V_SYNC);

    function automatic logic in_active(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] v);
        return ({1'b0, h} < H_ACT_END) && ({1'b0, v} < V_ACT_END);
    endfunction

    function automatic logic hsync_level(input logic [CNT_W-1:0] h);
        logic act;
        act = ({1'b0, h} >= HS_START) && ({1'b0, h} < HS_END);
        return act ? H_POL : ~H_POL;
    endfunction

    function automatic logic vsync_level(input logic [CNT_W-1:0] v);
        logic act;
        act = ({1'b0, v} >= VS_START) && ({1'b0, v} < VS_END);
        return act ? V_POL : ~V_POL;
    endfunction

    logic [CNT_W-1:0]   h_p1;
    logic [CNT_W-1:0]   v_p1;
    logic               hsync_p1;
    logic               vsync_p1;
    logic               de_p1;
    logic               line_start_p1;
    logic               frame_start_p1;
    logic [FRAME_W-1:0] frame_count_p1;

    logic [CNT_W-1:0]   h_p0;
    logic [CNT_W-1:0]   v_p0;
    logic               h_wrap_p0;
    logic               v_wrap_p0;

    // Stage p0: next raster position, valid whenever the enable is high.
    always_comb begin
        h_wrap_p0 = (h_p1 == H_LAST);
        v_wrap_p0 = (v_p1 == V_LAST);
        h_p0      = h_wrap_p0 ? '0 : h_p1 + CNT_W'(1);
        v_p0      = v_p1;
        if (h_wrap_p0) begin
            v_p0 = v_wrap_p0 ? '0 : v_p1 + CNT_W'(1);
        end
    end

    // Stage p1: levels decoded from p0 so they land in the same cycle as the coordinates.
    always_ff @(posedge clock) begin
        if (!reset) begin
            h_p1           <= H_LAST;
            v_p1           <= V_LAST;
            hsync_p1       <= ~H_POL;
            vsync_p1       <= ~V_POL;
            de_p1          <= 1'b0;
            line_start_p1  <= 1'b0;
            frame_start_p1 <= 1'b0;
            frame_count_p1 <= '0;
        end else if (vga.pixelEnable) begin
            h_p1           <= h_p0;
            v_p1           <= v_p0;
            hsync_p1       <= hsync_level(h_p0);
            vsync_p1       <= vsync_level(v_p0);
            de_p1          <= in_active(h_p0, v_p0);
            line_start_p1  <= h_wrap_p0;
            frame_start_p1 <= h_wrap_p0 && v_wrap_p0;
            if (h_wrap_p0 && v_wrap_p0) begin
                frame_count_p1 <= frame_count_p1 + FRAME_W'(1);
            end
        end else begin
            line_start_p1  <= 1'b0;
            frame_start_p1 <= 1'b0;
        end
    end

    assign vga.pixelH     = h_p1;
    assign vga.pixelV     = v_p1;
    assign vga.hsync      = hsync_p1;
    assign vga.vsync      = vsync_p1;
    assign vga.dataEnable = de_p1;
    assign vga.lineStart  = line_start_p1;
    assign vga.frameStart = frame_start_p1;
    assign vga.frameCount = frame_count_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three modes checked every cycle against a raster-index model,
// plus hand-computed literal expectations for periods, widths and reset values.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, fw;
    } mode_t;

    typedef struct {
        int h, v, hsync, vsync, de, ls, fs, fc;
    } obs_t;

    logic clock = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_c = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    vga_timing_gen_if #(.CNT_W(12), .FRAME_W(16)) ia ();
    vga_timing_gen_if #(.CNT_W(12), .FRAME_W(2))  ib ();
    vga_timing_gen_if #(.CNT_W(4),  .FRAME_W(2))  ic ();

    vga_timing_gen dut_a (.clock(clock), .reset(rst_a), .vga(ia));

    vga_timing_gen #(
        .H_ACTIVE(1280), .H_FP(110), .H_SYNC(40), .H_BP(220),
        .V_ACTIVE(720),  .V_FP(5),   .V_SYNC(5),  .V_BP(20),
        .H_POL(1'b1), .V_POL(1'b1), .CNT_W(12), .FRAME_W(2)
    ) dut_b (.clock(clock), .reset(rst_b), .vga(ib));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b0), .CNT_W(4), .FRAME_W(2)
    ) dut_c (.clock(clock), .reset(rst_c), .vga(ic));

    mode_t mode_a = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 16};
    mode_t mode_b = '{1280, 110, 40, 220, 720, 5, 5, 20, 1, 1, 2};
    mode_t mode_c = '{8, 2, 3, 2, 4, 1, 2, 1, 1, 0, 2};

    // k counts enabled edges since the last reset edge; the raster index is (k-1) mod total.
    function automatic obs_t model(input mode_t m, input longint k, input bit adv);
        obs_t   e;
        longint ht, vt, tot, idx;
        ht  = longint'(m.ha + m.hf + m.hs + m.hb);
        vt  = longint'(m.va + m.vf + m.vs + m.vb);
        tot = ht * vt;
        if (k == 0) begin
            e = '{int'(ht - 1), int'(vt - 1), 1 - m.hp, 1 - m.vp, 0, 0, 0, 0};
            return e;
        end
        idx     = (k - 1) % tot;
        e.h     = int'(idx % ht);
        e.v     = int'(idx / ht);
        e.de    = (e.h < m.ha && e.v < m.va) ? 1 : 0;
        e.hsync = (e.h >= m.ha + m.hf && e.h < m.ha + m.hf + m.hs) ? m.hp : 1 - m.hp;
        e.vsync = (e.v >= m.va + m.vf && e.v < m.va + m.vf + m.vs) ? m.vp : 1 - m.vp;
        e.ls    = (adv && e.h == 0) ? 1 : 0;
        e.fs    = (adv && idx == 0) ? 1 : 0;
        e.fc    = int'(((k + tot - 1) / tot) % (longint'(1) << m.fw));
        return e;
    endfunction

    function automatic obs_t pack(input int h, input int v, input int hs, input int vs,
                                  input int de, input int ls, input int fs, input int fc);
        obs_t o;
        o = '{h, v, hs, vs, de, ls, fs, fc};
        return o;
    endfunction

    task automatic check(input string n, input obs_t e, input obs_t a);
        compared++;
        if (e.h != a.h || e.v != a.v || e.hsync != a.hsync || e.vsync != a.vsync ||
            e.de != a.de || e.ls != a.ls || e.fs != a.fs || e.fc != a.fc) begin
            mismatched++;
            $display("FAIL %s: got h=%0d v=%0d hs=%0d vs=%0d de=%0d ls=%0d fs=%0d fc=%0d required h=%0d v=%0d hs=%0d vs=%0d de=%0d ls=%0d fs=%0d fc=%0d",
                     n, a.h, a.v, a.hsync, a.vsync, a.de, a.ls, a.fs, a.fc,
                     e.h, e.v, e.hsync, e.vsync, e.de, e.ls, e.fs, e.fc);
        end
    endtask

    task automatic lit(input string n, input longint act, input longint req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d required %0d", n, act, req);
        end
    endtask

    longint k_a = 0, k_b = 0, k_c = 0;
    bit     adv_a = 0, adv_b = 0, adv_c = 0;
    bit     vld_a = 0, vld_b = 0, vld_c = 0;

    always @(posedge clock) begin
        if (!rst_a) begin k_a <= 0; adv_a <= 0; vld_a <= 1; end
        else if (ia.pixelEnable) begin k_a <= k_a + 1; adv_a <= 1; end
        else adv_a <= 0;
        if (!rst_b) begin k_b <= 0; adv_b <= 0; vld_b <= 1; end
        else if (ib.pixelEnable) begin k_b <= k_b + 1; adv_b <= 1; end
        else adv_b <= 0;
        if (!rst_c) begin k_c <= 0; adv_c <= 0; vld_c <= 1; end
        else if (ic.pixelEnable) begin k_c <= k_c + 1; adv_c <= 1; end
        else adv_c <= 0;
    end

    always @(negedge clock) begin
        if (vld_a)
            check("model_a", model(mode_a, k_a, adv_a),
                  pack(int'(ia.pixelH), int'(ia.pixelV), int'(ia.hsync), int'(ia.vsync),
                       int'(ia.dataEnable), int'(ia.lineStart), int'(ia.frameStart), int'(ia.frameCount)));
        if (vld_b)
            check("model_b", model(mode_b, k_b, adv_b),
                  pack(int'(ib.pixelH), int'(ib.pixelV), int'(ib.hsync), int'(ib.vsync),
                       int'(ib.dataEnable), int'(ib.lineStart), int'(ib.frameStart), int'(ib.frameCount)));
        if (vld_c)
            check("model_c", model(mode_c, k_c, adv_c),
                  pack(int'(ic.pixelH), int'(ic.pixelV), int'(ic.hsync), int'(ic.vsync),
                       int'(ic.dataEnable), int'(ic.lineStart), int'(ic.frameStart), int'(ic.frameCount)));
    end

    initial begin
        int n, cnt, first, hmax, found, p1, p2, consec;
        bit prev;
        ia.pixelEnable = 1'b0;
        ib.pixelEnable = 1'b0;
        ic.pixelEnable = 1'b0;
        repeat (3) @(negedge clock);

        // Reset state
        lit("a_rst_h", longint'(ia.pixelH), 799);
        lit("a_rst_v", longint'(ia.pixelV), 524);
        lit("a_rst_de", longint'(ia.dataEnable), 0);
        lit("a_rst_hsync", longint'(ia.hsync), 1);
        lit("a_rst_fc", longint'(ia.frameCount), 0);
        lit("c_rst_h", longint'(ic.pixelH), 14);

        // Default mode, enable tied high
        rst_a = 1'b1;
        ia.pixelEnable = 1'b1;
        @(negedge clock);
        lit("a_first_h", longint'(ia.pixelH), 0);
        lit("a_first_v", longint'(ia.pixelV), 0);
        lit("a_first_de", longint'(ia.dataEnable), 1);
        lit("a_first_fs", longint'(ia.frameStart), 1);
        lit("a_first_fc", longint'(ia.frameCount), 1);

        n = 0;
        do begin @(negedge clock); n++; end while (!ia.lineStart && n < 2000);
        lit("a_line_period", n, 800);

        cnt = 0; first = -1; n = 0;
        for (int i = 0; i < 800; i++) begin
            if (!ia.hsync) begin cnt++; if (first < 0) first = int'(ia.pixelH); end
            if (ia.dataEnable) n++;
            @(negedge clock);
        end
        lit("a_hsync_low_clocks", cnt, 96);
        lit("a_hsync_first_h", first, 656);
        lit("a_de_clocks", n, 640);

        // Mid-frame reset
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            if (ia.pixelH == 12'd300 && ia.pixelV == 12'd2) begin found = 1; break; end
            @(negedge clock);
        end
        lit("a_reach_300_2", found, 1);
        rst_a = 1'b0;
        @(negedge clock);
        lit("a_mid_rst_h", longint'(ia.pixelH), 799);
        lit("a_mid_rst_v", longint'(ia.pixelV), 524);
        lit("a_mid_rst_de", longint'(ia.dataEnable), 0);
        lit("a_mid_rst_hsync", longint'(ia.hsync), 1);
        lit("a_mid_rst_vsync", longint'(ia.vsync), 1);
        lit("a_mid_rst_fc", longint'(ia.frameCount), 0);
        rst_a = 1'b1;
        @(negedge clock);
        lit("a_restart_h", longint'(ia.pixelH), 0);
        lit("a_restart_fs", longint'(ia.frameStart), 1);
        lit("a_restart_fc", longint'(ia.frameCount), 1);

        // Half-rate enable
        p1 = -1; p2 = -1; consec = 0; prev = 1'b0;
        for (int i = 0; i < 3300; i++) begin
            ia.pixelEnable = i[0];
            @(negedge clock);
            if (ia.lineStart) begin
                if (p1 < 0) p1 = i; else if (p2 < 0) p2 = i;
                if (prev) consec++;
            end
            prev = ia.lineStart;
        end
        lit("a_half_rate_line_period", p2 - p1, 1600);
        lit("a_half_rate_ls_wide", consec, 0);
        ia.pixelEnable = 1'b1;

        // Alternate 1650x750 mode, active-high syncs
        rst_b = 1'b1;
        ib.pixelEnable = 1'b1;
        @(negedge clock);
        lit("b_first_fs", longint'(ib.frameStart), 1);
        cnt = 0; first = -1; hmax = 0;
        for (int i = 0; i < 1650; i++) begin
            if (ib.hsync) begin cnt++; if (first < 0) first = int'(ib.pixelH); end
            if (int'(ib.pixelH) > hmax) hmax = int'(ib.pixelH);
            @(negedge clock);
        end
        lit("b_hsync_high_clocks", cnt, 40);
        lit("b_hsync_first_h", first, 1390);
        lit("b_h_max", hmax, 1649);
        lit("b_line1_v", longint'(ib.pixelV), 1);

        // Small mode: full frames, vsync, frame counter wrap
        rst_c = 1'b1;
        ic.pixelEnable = 1'b1;
        @(negedge clock);
        cnt = 0; first = -1; n = -1;
        for (int i = 0; i < 120; i++) begin
            if (!ic.vsync) begin
                cnt++;
                if (first < 0) begin first = int'(ic.pixelV); n = int'(ic.pixelH); end
            end
            @(negedge clock);
        end
        lit("c_vsync_low_clocks", cnt, 30);
        lit("c_vsync_first_v", first, 5);
        lit("c_vsync_first_h", n, 0);
        lit("c_frame2_fs", longint'(ic.frameStart), 1);
        lit("c_frame2_fc", longint'(ic.frameCount), 2);
        repeat (120) @(negedge clock);
        lit("c_frame3_fc", longint'(ic.frameCount), 3);
        repeat (120) @(negedge clock);
        lit("c_wrap_fs", longint'(ic.frameStart), 1);
        lit("c_wrap_fc", longint'(ic.frameCount), 0);

        p1 = -1; p2 = -1; cnt = 0;
        for (int i = 0; i < 600; i++) begin
            ic.pixelEnable = i[0];
            @(negedge clock);
            if (ic.frameStart) begin
                cnt++;
                if (p1 < 0) p1 = i; else if (p2 < 0) p2 = i;
            end
        end
        lit("c_half_rate_frame_period", p2 - p1, 240);
        lit("c_half_rate_fs_clocks", cnt, 2);

        repeat (4) @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator for the VGA/HDMI output path; successor to the fixed 640x480@60 sync block.
- Produces the pixel coordinates, hsync/vsync, dataEnable, line/frame strobes and a frame counter for any mode set by parameters.
- Runs on a single system clock with a pixel-rate clock enable, so no derived clock leaves the block.
- Feeds the pixel renderer and the HDMI transmitter interface.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- CNT_W, 12, width of the coordinate counters
- FRAME_W, 16, width of the frame counter

Ports:
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-low reset
- pixelEnable  in  1  pixel-rate clock enable; the raster advances only on cycles where it is 1
- pixelH  out  CNT_W  current horizontal position, 0..H_TOTAL-1
- pixelV  out  CNT_W  current vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync at H_POL level when active
- vsync  out  1  vertical sync at V_POL level when active
- dataEnable  out  1  1 while (pixelH,pixelV) is inside the active area
- lineStart  out  1  one-clock strobe on entry to pixelH==0
- frameStart  out  1  one-clock strobe on entry to (0,0)
- frameCount  out  FRAME_W  count of completed frame starts

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). Both totals must fit in CNT_W; this is checked at elaboration.
- Reset (reset==0 at a clock edge, highest priority, overrides pixelEnable):
  - pixelH=H_TOTAL-1, pixelV=V_TOTAL-1
  - hsync=~H_POL, vsync=~V_POL
  - dataEnable=0, lineStart=0, frameStart=0, frameCount=0
  - Reset asserted mid-frame takes effect at the next edge; no partial line is completed.
- Advance (pixelEnable==1, reset==1):
  - If pixelH<H_TOTAL-1, pixelH increments.
  - Otherwise pixelH wraps to 0 and pixelV increments, wrapping from V_TOTAL-1 to 0.
- Hold (pixelEnable==0): all counters and levels hold; lineStart and frameStart are 0.
- Output alignment:
  - All outputs are registered and describe the same (pixelH,pixelV) in the same cycle, with zero skew between coordinates and hsync/vsync/dataEnable.
  - To achieve this, the level outputs are decoded from the next-state counter values.
- Decodes, with h,v being the registered position:
  - dataEnable = (h<H_ACTIVE) && (v<V_ACTIVE)
  - hsync is active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (default 656..751)
  - vsync is active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (default lines 490..491); it changes only together with the pixelV change at h=0
- Strobes:
  - lineStart=1 for exactly one clock, on the enabled edge that moves pixelH to 0.
  - frameStart=1 for exactly one clock, on the enabled edge that moves to (0,0); lineStart is also 1 on that edge.
- frameCount increments on the same edge frameStart is set and wraps modulo 2^FRAME_W.
- After reset release, the first enabled edge yields (0,0) with dataEnable=1, frameStart=1 and frameCount=1.

Test Plan:
- Reset, then pixelEnable tied 1, default parameters:
  - First edge gives (0,0), dataEnable=1, frameStart=1, frameCount=1.
  - frameStart recurs every 420000 clocks.
- Horizontal timing, one line:
  - dataEnable is 1 for h 0..639; hsync is 0 exactly for h 656..751 (96 clocks).
  - lineStart pulses every 800 clocks.
- Vertical timing:
  - vsync is 0 for exactly 1600 clocks, starting at (0,490).
  - dataEnable is 0 on every pixel with v>=480.
  - pixelV wraps from 524 to 0.
- pixelEnable toggling 1,0 (pixel rate = half clock):
  - Frame period is 840000 clocks.
  - Strobes remain one clock wide; outputs hold on disabled cycles.
- Reset asserted at (300,200) while pixelEnable=1:
  - Next edge shows (799,524), dataEnable=0, syncs inactive, frameCount=0.
  - Restart behaves as in the first scenario.
- Alternate mode H=1280/110/40/220, V=720/5/5/20, H_POL=V_POL=1, FRAME_W=2:
  - Totals are 1650x750; hsync is high for h 1390..1429; vsync is high for v 725..729.
  - frameCount wraps from 3 to 0.
